rv32i_decoder: RTL and testbench

- Registered RV32I instruction decoder between the fetch stage and the register-file/ALU stage.
- Classifies a 32-bit instruction by opcode into one-hot type flags.
- Extracts register indices, funct3 and funct7.
- Produces all five sign-extended immediates (U/I/S/B/J).
- Outputs are registered, so latency is one clock.

---
 rtl/rv32i_pkg.sv | 40 ++++
 rtl/rv32i_imm_gen.sv | 26 ++
 rtl/rv32i_decoder.sv | 127 ++++++++++++
 tb/tb_rv32i_decoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions.
//   XLEN          : data/immediate width (only 32 is supported)
//   OP_*          : 7-bit major opcodes recognised by the decoder
//   dec_fields_t  : per-instruction type flags and register/function fields
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_ALUREG = 7'b0110011;
    localparam logic [6:0] OP_ALUIMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef struct packed {
        logic       is_alu_reg;
        logic       is_alu_imm;
        logic       is_branch;
        logic       is_jalr;
        logic       is_jal;
        logic       is_auipc;
        logic       is_lui;
        logic       is_load;
        logic       is_store;
        logic       is_system;
        logic       is_illegal;
        logic [4:0] rs1_id;
        logic [4:0] rs2_id;
        logic [4:0] rd_id;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } dec_fields_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate generator for RV32I.
//   instr                       in  : 32-bit instruction word
//   Uimm/Iimm/Simm/Bimm/Jimm    out : sign-extended immediates of each format
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] Uimm,
    output logic [XLEN-1:0] Iimm,
    output logic [XLEN-1:0] Simm,
    output logic [XLEN-1:0] Bimm,
    output logic [XLEN-1:0] Jimm
);

    logic w_sign;
    assign w_sign = instr[31];

    // Every format takes its sign from instr[31], so the top bit is copied
    // out to XLEN rather than being treated as part of the magnitude.
    assign Uimm = {{(XLEN-31){w_sign}}, instr[30:12], 12'b0};
    assign Iimm = {{(XLEN-11){w_sign}}, instr[30:20]};
    assign Simm = {{(XLEN-11){w_sign}}, instr[30:25], instr[11:7]};
    assign Bimm = {{(XLEN-12){w_sign}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign Jimm = {{(XLEN-20){w_sign}}, instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/rv32i_decoder.sv
// Registered RV32I instruction decoder (fetch -> regfile/ALU), latency 1.
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   instr, instr_valid : instruction word and its qualifier
//   out_valid          : outputs belong to an instruction captured last cycle
//   is*                : one-hot opcode class flags, isIllegal for unknown opcodes
//   *imm               : U/I/S/B/J immediates, always extracted
//   rs1Id/rs2Id/rdId, funct3, funct7 : raw instruction fields
// When instr_valid is low, out_valid drops and everything else holds.
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic            out_valid,
    output logic            isALUreg,
    output logic            isALUimm,
    output logic            isBranch,
    output logic            isJALR,
    output logic            isJAL,
    output logic            isAUIPC,
    output logic            isLUI,
    output logic            isLoad,
    output logic            isStore,
    output logic            isSYSTEM,
    output logic            isIllegal,
    output logic [XLEN-1:0] Uimm,
    output logic [XLEN-1:0] Iimm,
    output logic [XLEN-1:0] Simm,
    output logic [XLEN-1:0] Bimm,
    output logic [XLEN-1:0] Jimm,
    output logic [4:0]      rs1Id,
    output logic [4:0]      rs2Id,
    output logic [4:0]      rdId,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7
);

    dec_fields_t     w_dec;
    dec_fields_t     r_dec;
    logic            r_out_valid;
    logic [XLEN-1:0] w_uimm, w_iimm, w_simm, w_bimm, w_jimm;
    logic [XLEN-1:0] r_uimm, r_iimm, r_simm, r_bimm, r_jimm;

    rv32i_imm_gen u_imm_gen (
        .instr (instr),
        .Uimm  (w_uimm),
        .Iimm  (w_iimm),
        .Simm  (w_simm),
        .Bimm  (w_bimm),
        .Jimm  (w_jimm)
    );

    always_comb begin
        // NOTE: clearing the whole struct first gives every bit a value on
        // every path, so no latch can be inferred for the flags.
        w_dec        = '0;
        w_dec.rs1_id = instr[19:15];
        w_dec.rs2_id = instr[24:20];
        w_dec.rd_id  = instr[11:7];
        w_dec.funct3 = instr[14:12];
        w_dec.funct7 = instr[31:25];
        case (instr[6:0])
            OP_ALUREG: w_dec.is_alu_reg = 1'b1;
            OP_ALUIMM: w_dec.is_alu_imm = 1'b1;
            OP_BRANCH: w_dec.is_branch  = 1'b1;
            OP_JALR:   w_dec.is_jalr    = 1'b1;
            OP_JAL:    w_dec.is_jal     = 1'b1;
            OP_AUIPC:  w_dec.is_auipc   = 1'b1;
            OP_LUI:    w_dec.is_lui     = 1'b1;
            OP_LOAD:   w_dec.is_load    = 1'b1;
            OP_STORE:  w_dec.is_store   = 1'b1;
            OP_SYSTEM: w_dec.is_system  = 1'b1;
            OP_FENCE:  ;                // executed as a NOP: no flag, not illegal
            default:   w_dec.is_illegal = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_dec       <= '0;
            r_uimm      <= '0;
            r_iimm      <= '0;
            r_simm      <= '0;
            r_bimm      <= '0;
            r_jimm      <= '0;
        end else begin
            r_out_valid <= instr_valid;
            if (instr_valid) begin
                r_dec  <= w_dec;
                r_uimm <= w_uimm;
                r_iimm <= w_iimm;
                r_simm <= w_simm;
                r_bimm <= w_bimm;
                r_jimm <= w_jimm;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign isALUreg  = r_dec.is_alu_reg;
    assign isALUimm  = r_dec.is_alu_imm;
    assign isBranch  = r_dec.is_branch;
    assign isJALR    = r_dec.is_jalr;
    assign isJAL     = r_dec.is_jal;
    assign isAUIPC   = r_dec.is_auipc;
    assign isLUI     = r_dec.is_lui;
    assign isLoad    = r_dec.is_load;
    assign isStore   = r_dec.is_store;
    assign isSYSTEM  = r_dec.is_system;
    assign isIllegal = r_dec.is_illegal;
    assign rs1Id     = r_dec.rs1_id;
    assign rs2Id     = r_dec.rs2_id;
    assign rdId      = r_dec.rd_id;
    assign funct3    = r_dec.funct3;
    assign funct7    = r_dec.funct7;
    assign Uimm      = r_uimm;
    assign Iimm      = r_iimm;
    assign Simm      = r_simm;
    assign Bimm      = r_bimm;
    assign Jimm      = r_jimm;

endmodule

// File: tb/tb_rv32i_decoder.sv
// Self-checking bench for rv32i_decoder: directed vectors followed by random
// instructions, valid gaps and resets, all compared against an arithmetic
// reference model of the decoder's rules.
module tb_rv32i_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        out_valid;
    logic        isALUreg, isALUimm, isBranch, isJALR, isJAL, isAUIPC, isLUI;
    logic        isLoad, isStore, isSYSTEM, isIllegal;
    logic [31:0] Uimm, Iimm, Simm, Bimm, Jimm;
    logic [4:0]  rs1Id, rs2Id, rdId;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rv32i_decoder dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .out_valid(out_valid),
        .isALUreg(isALUreg), .isALUimm(isALUimm), .isBranch(isBranch),
        .isJALR(isJALR), .isJAL(isJAL), .isAUIPC(isAUIPC), .isLUI(isLUI),
        .isLoad(isLoad), .isStore(isStore), .isSYSTEM(isSYSTEM),
        .isIllegal(isIllegal),
        .Uimm(Uimm), .Iimm(Iimm), .Simm(Simm), .Bimm(Bimm), .Jimm(Jimm),
        .rs1Id(rs1Id), .rs2Id(rs2Id), .rdId(rdId),
        .funct3(funct3), .funct7(funct7)
    );

    // Flag index order: ALUreg, ALUimm, Branch, JALR, JAL, AUIPC, LUI,
    // Load, Store, SYSTEM; index 10 is isIllegal.
    logic [6:0] opcodes [10] = '{7'h33, 7'h13, 7'h63, 7'h67, 7'h6F,
                                 7'h17, 7'h37, 7'h03, 7'h23, 7'h73};

    // Reference state
    logic        m_valid;
    logic [10:0] m_flags;
    logic [31:0] m_u, m_i, m_s, m_b, m_j;
    int          m_rs1, m_rs2, m_rd, m_f3, m_f7;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Field value of instr[hi:lo] by shifting and masking.
    function automatic int fld(input logic [31:0] w, input int hi, input int lo);
        return int'((w >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
    endfunction

    // Sign-interpret an n-bit unsigned value, returned as a 32-bit word.
    function automatic logic [31:0] sx(input int v, input int nbits);
        int r;
        r = (v >= (1 << (nbits - 1))) ? v - (1 << nbits) : v;
        return 32'(r);
    endfunction

    task automatic model_step(input logic rst, input logic v, input logic [31:0] w);
        if (rst) begin
            m_valid = 0; m_flags = '0;
            m_u = 0; m_i = 0; m_s = 0; m_b = 0; m_j = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0;
        end else begin
            m_valid = v;
            if (v) begin
                int op;
                op = fld(w, 6, 0);
                m_flags = '0;
                if (op != 'h0F) m_flags[10] = 1'b1;
                for (int k = 0; k < 10; k++)
                    if (op == int'(opcodes[k])) begin
                        m_flags = '0;
                        m_flags[k] = 1'b1;
                    end
                m_rs1 = fld(w, 19, 15);
                m_rs2 = fld(w, 24, 20);
                m_rd  = fld(w, 11, 7);
                m_f3  = fld(w, 14, 12);
                m_f7  = fld(w, 31, 25);
                m_u = 32'(fld(w, 31, 12) * 4096);
                m_i = sx(fld(w, 31, 20), 12);
                m_s = sx(fld(w, 31, 25) * 32 + fld(w, 11, 7), 12);
                m_b = sx(fld(w, 31, 31) * 4096 + fld(w, 7, 7) * 2048
                         + fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2, 13);
                m_j = sx(fld(w, 31, 31) * (1 << 20) + fld(w, 19, 12) * 4096
                         + fld(w, 20, 20) * 2048 + fld(w, 30, 21) * 2, 21);
            end
        end
    endtask

    task automatic check_all();
        logic [10:0] flags;
        flags = {isIllegal, isSYSTEM, isStore, isLoad, isLUI, isAUIPC,
                 isJAL, isJALR, isBranch, isALUimm, isALUreg};
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("flags",     32'(flags),     32'(m_flags));
        check("Uimm", Uimm, m_u);
        check("Iimm", Iimm, m_i);
        check("Simm", Simm, m_s);
        check("Bimm", Bimm, m_b);
        check("Jimm", Jimm, m_j);
        check("rs1Id",  32'(rs1Id),  32'(m_rs1));
        check("rs2Id",  32'(rs2Id),  32'(m_rs2));
        check("rdId",   32'(rdId),   32'(m_rd));
        check("funct3", 32'(funct3), 32'(m_f3));
        check("funct7", 32'(funct7), 32'(m_f7));
    endtask

    // Apply inputs, take one edge, sample 1 time unit later.
    task automatic cycle(input logic rst, input logic v, input logic [31:0] w);
        reset = rst; instr_valid = v; instr = w;
        @(posedge clk);
        #1;
        model_step(rst, v, w);
        check_all();
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b1; instr = 32'h00A50533;
        model_step(1'b1, 1'b0, 32'h0);

        // Reset held two cycles with a valid instruction presented
        cycle(1'b1, 1'b1, 32'h00A50533);
        cycle(1'b1, 1'b1, 32'h00A50533);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_rd",    32'(rdId),      32'd0);

        cycle(1'b0, 1'b1, 32'h00A50533);
        check("r_alureg", 32'(isALUreg), 32'd1);
        check("r_rd",     32'(rdId),     32'd10);
        check("r_rs2",    32'(rs2Id),    32'd10);

        cycle(1'b0, 1'b1, 32'h00A58513);
        check("i_aluimm", 32'(isALUimm), 32'd1);
        check("i_rs1",    32'(rs1Id),    32'd11);
        check("i_imm",    Iimm,          32'h0000000A);

        cycle(1'b0, 1'b1, 32'h00008067);
        check("jalr_flag", 32'(isJALR), 32'd1);
        check("jalr_rs1",  32'(rs1Id),  32'd1);

        cycle(1'b0, 1'b1, 32'hFE000EE3);
        check("b_flag", 32'(isBranch), 32'd1);
        check("b_imm",  Bimm,          32'hFFFFFFFC);

        cycle(1'b0, 1'b1, 32'h0000006F);
        check("jal_flag", 32'(isJAL), 32'd1);
        cycle(1'b0, 1'b1, 32'h00000517);
        check("auipc_rd", 32'(rdId), 32'd10);
        cycle(1'b0, 1'b1, 32'h12345037);
        check("lui_imm", Uimm, 32'h12345000);

        cycle(1'b0, 1'b1, 32'h00000000);
        check("ill_flag", 32'(isIllegal), 32'd1);
        cycle(1'b0, 1'b0, 32'hFFFFFFFF);
        check("hold_valid", 32'(out_valid), 32'd0);
        check("hold_ill",   32'(isIllegal), 32'd1);
        cycle(1'b0, 1'b1, 32'h0000000F);
        check("fence_ill", 32'(isIllegal), 32'd0);

        // Reset mid-stream drops the in-flight instruction
        cycle(1'b0, 1'b1, 32'h00A58513);
        cycle(1'b1, 1'b1, 32'h12345037);
        check("midrst_lui", 32'(isLUI), 32'd0);

        // Random stimulus: half with a legal/FENCE opcode, half fully random
        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            logic        v, r;
            w = $urandom;
            if ($urandom_range(1, 0) == 1) begin
                int k;
                k = $urandom_range(10, 0);
                w[6:0] = (k == 10) ? 7'h0F : opcodes[k];
            end
            v = ($urandom_range(3, 0) != 0);
            r = ($urandom_range(31, 0) == 0);
            cycle(r, v, w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
